fib_uart_tx: RTL and testbench

- Downstream consumer of the Fibonacci generator's 8-bit output bus. That bus changes at the divided fib_clk rate and is quasi-static from this block's point of view.
- Runs on the fast system clock and qualifies each new value by a stability filter.
- Holds one pending value and serializes it as an 8N1 UART frame on a single tx pin, for board-level observation of the sequence.
- Counts values lost when the generator outpaces the UART.

---
 rtl/fib_uart_tx.sv | 151 +++++++++++++++
 tb/tb_fib_uart_tx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fib_uart_tx.sv
// Samples the Fibonacci generator's quasi-static output bus and accepts each new stable value.
// Each accepted value goes out as one 8N1 UART frame on tx. Values lost to overrun are counted.
module fib_uart_tx #(
    parameter logic [15:0] CLK_PER_BIT   = 16'd868,
    parameter logic [7:0]  STABLE_CYCLES = 8'd4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    output logic       tx,
    output logic       busy,
    output logic [7:0] overrun_cnt
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [7:0]  STABLE_LAST = STABLE_CYCLES - 8'd1;
    localparam logic [15:0] BIT_LAST    = CLK_PER_BIT - 16'd1;

    logic [7:0]  r_d1, r_d2, r_stable_cnt, r_last, r_pending, r_shreg, r_overrun;
    logic        r_first, r_pending_valid, r_tx, r_busy;
    logic [15:0] r_bit_cnt;
    logic [2:0]  r_idx;
    state_t      r_state;

    state_t      w_state_nxt;
    logic [15:0] w_bit_cnt_nxt;
    logic [2:0]  w_idx_nxt;
    logic [7:0]  w_shreg_nxt;
    logic        w_tx_nxt, w_load, w_accept, w_pending_valid_nxt, w_bit_done;

    // Two-flop sampling plus a run-length counter on the sampled bus.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_d1         <= 8'd0;
            r_d2         <= 8'd0;
            r_stable_cnt <= 8'd0;
            r_first      <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep r_d2 loading the old r_d1, not the new one.
            r_d1 <= din;
            r_d2 <= r_d1;
            if (r_d1 != r_d2)
                r_stable_cnt <= 8'd0;
            else if (r_stable_cnt != STABLE_CYCLES)
                r_stable_cnt <= r_stable_cnt + 8'd1;
            if (w_accept)
                r_first <= 1'b0;
        end
    end

    assign w_accept = (r_d1 == r_d2) && (r_stable_cnt == STABLE_LAST) &&
                      (r_first || (r_d2 != r_last));

    // NOTE: no reset here on purpose; r_first and r_pending_valid mask these until first written.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_last    <= r_d2;
            r_pending <= r_d2;
        end
    end

    // A load in the same cycle as an accept frees the slot, so that is not an overrun.
    assign w_pending_valid_nxt = w_accept ? 1'b1 : (w_load ? 1'b0 : r_pending_valid);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending_valid <= 1'b0;
            r_overrun       <= 8'd0;
        end else begin
            r_pending_valid <= w_pending_valid_nxt;
            if (w_accept && r_pending_valid && !w_load && (r_overrun != 8'hFF))
                r_overrun <= r_overrun + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_bit_cnt <= 16'd0;
            r_idx     <= 3'd0;
            r_shreg   <= 8'd0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_shreg   <= w_shreg_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= (w_state_nxt != IDLE) || w_pending_valid_nxt;
        end
    end

    assign w_bit_done = (r_bit_cnt == BIT_LAST);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt + 16'd1;
        w_idx_nxt     = r_idx;
        w_shreg_nxt   = r_shreg;
        w_tx_nxt      = r_tx;
        w_load        = 1'b0;
        case (r_state)
            IDLE: begin
                w_tx_nxt      = 1'b1;
                w_bit_cnt_nxt = 16'd0;
                if (r_pending_valid) begin
                    w_load      = 1'b1;
                    w_shreg_nxt = r_pending;
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_bit_done) begin
                    w_bit_cnt_nxt = 16'd0;
                    w_tx_nxt      = r_shreg[0];
                    w_idx_nxt     = 3'd0;
                    w_state_nxt   = DATA;
                end
            end
            DATA: begin
                // The shift register keeps the bit on the line at position 0.
                if (w_bit_done) begin
                    w_bit_cnt_nxt = 16'd0;
                    if (r_idx == 3'd7) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = STOP;
                    end else begin
                        w_idx_nxt   = r_idx + 3'd1;
                        w_shreg_nxt = {1'b0, r_shreg[7:1]};
                        w_tx_nxt    = r_shreg[1];
                    end
                end
            end
            STOP: begin
                if (w_bit_done) begin
                    w_bit_cnt_nxt = 16'd0;
                    w_state_nxt   = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign tx          = r_tx;
    assign busy        = r_busy;
    assign overrun_cnt = r_overrun;

endmodule

// File: tb/tb_fib_uart_tx.sv
// Directed bench for fib_uart_tx with CLK_PER_BIT=4 and STABLE_CYCLES=2.
// Frames are decoded by sampling tx at mid-bit on falling clock edges.
module tb_fib_uart_tx;
    localparam int CPB = 4;
    localparam int SC  = 2;
    localparam int MID = CPB / 2;

    logic       clk;
    logic       reset;
    logic [7:0] din;
    logic       tx;
    logic       busy;
    logic [7:0] overrun_cnt;

    int checks   = 0;
    int failures = 0;

    fib_uart_tx #(
        .CLK_PER_BIT  (16'(CPB)),
        .STABLE_CYCLES(8'(SC))
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .tx         (tx),
        .busy       (busy),
        .overrun_cnt(overrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns at the first falling edge where tx is low (start-bit position 0), or after limit samples.
    task automatic wait_fall(input int limit, output int n_high);
        n_high = 0;
        @(negedge clk);
        while ((tx === 1'b1) && (n_high < limit)) begin
            n_high++;
            @(negedge clk);
        end
    endtask

    // Called at start-bit position 0; returns at the middle of the stop bit.
    task automatic recv_body(output logic [7:0] data, output logic start_bit, output logic stop_bit);
        repeat (MID) @(negedge clk);
        start_bit = tx;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            data[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        stop_bit = tx;
    endtask

    initial begin
        logic [9:0] frame;
        logic [7:0] d0, d1;
        logic       sb0, pb0, sb1, pb1;
        int         n, gap;
        bit         idle_ok;

        // 1: reset held with a live value on din
        reset = 1'b0;
        din   = 8'h37;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", overrun_cnt, 8'h00);

        // 2: release with din=01; edge 0 is the edge just before the change
        @(posedge clk); #1;
        reset = 1'b1;
        din   = 8'h01;
        repeat (4) @(posedge clk); #1;
        check("s2_high_before_edge5", tx, 1'b1);
        @(posedge clk); #1;
        check("s2_fall_at_edge5", tx, 1'b0);
        frame = {1'b1, 8'h01, 1'b0};
        for (int j = 0; j < 10; j++) begin
            for (int k = 0; k < CPB; k++) begin
                check("s2_frame_bit", tx, frame[j]);
                check("s2_busy_in_frame", busy, 1'b1);
                @(posedge clk); #1;
            end
        end
        check("s2_busy_after_stop", busy, 1'b0);
        check("s2_tx_idle", tx, 1'b1);

        // 3: unchanged value must not be resent
        idle_ok = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if ((tx !== 1'b1) || (busy !== 1'b0)) idle_ok = 1'b0;
        end
        check("s3_no_resend", idle_ok, 1'b1);

        // 4: unstable bus, then settle on 08
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    @(posedge clk); #1;
                    din = (i % 2 == 0) ? 8'h05 : 8'h06;
                end
                @(posedge clk); #1;
                din = 8'h08;
            end
            begin
                wait_fall(400, n);
                recv_body(d0, sb0, pb0);
            end
        join
        check("s4_found", n < 400, 1'b1);
        check("s4_no_frame_while_toggling", n >= 20, 1'b1);
        check("s4_start", sb0, 1'b0);
        check("s4_data", d0, 8'h08);
        check("s4_stop", pb0, 1'b1);
        wait_fall(100, n);
        check("s4_single_frame", n, 100);

        // 5: 02, 03, 05 each for 10 clk; 03 is overwritten while 02 is in flight
        fork
            begin
                @(posedge clk); #1;
                din = 8'h02;
                repeat (10) @(posedge clk); #1;
                din = 8'h03;
                repeat (10) @(posedge clk); #1;
                din = 8'h05;
            end
            begin
                wait_fall(200, n);
                recv_body(d0, sb0, pb0);
                wait_fall(200, gap);
                recv_body(d1, sb1, pb1);
            end
        join
        check("s5_first_data", d0, 8'h02);
        check("s5_first_stop", pb0, 1'b1);
        check("s5_second_start", sb1, 1'b0);
        check("s5_second_data", d1, 8'h05);
        check("s5_second_stop", pb1, 1'b1);
        // high samples after mid-stop: rest of the stop bit plus exactly one idle cycle
        check("s5_gap", gap, CPB - 1 - MID + 1);
        check("s5_overrun", overrun_cnt, 8'h01);
        repeat (2 * CPB) @(negedge clk);
        check("s5_idle_busy", busy, 1'b0);

        // 6: reset during data bit 3 of 0D, then the same value is resent
        @(posedge clk); #1;
        din = 8'h0D;
        wait_fall(200, n);
        check("s6_found", n < 200, 1'b1);
        repeat (MID + 4 * CPB) @(negedge clk);
        check("s6_bit3", tx, 1'b1);
        check("s6_busy_mid_frame", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("s6_tx_on_reset", tx, 1'b1);
        check("s6_busy_on_reset", busy, 1'b0);
        check("s6_overrun_on_reset", overrun_cnt, 8'h00);
        repeat (3) @(posedge clk); #1;
        reset = 1'b1;
        wait_fall(200, n);
        check("s6_latency", n, SC + 3);
        recv_body(d0, sb0, pb0);
        check("s6_start", sb0, 1'b0);
        check("s6_data", d0, 8'h0D);
        check("s6_stop", pb0, 1'b1);
        wait_fall(100, n);
        check("s6_single_frame", n, 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
